named_decode: RTL and testbench
===============================

Name: named_decode

Overview:
- Receive-side counterpart of the named-counter encoder. That encoder emits XOUT = (A + B) - named, where named is a per-clock running counter: it is 0 at reset, is incremented before use, and so equals 1 in the first cycle.
- This block regenerates the same counter locally, restores SUM = XIN + key (mod 2^NBITS) and tags each word with its key.
- Results are buffered in a small FIFO with a valid/ready output handshake, so a downstream consumer can apply backpressure.

Parameters:
- NBITS, 8, data and counter width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- FREE_RUN, 1, counter mode. 1 = counter advances every clock, lock-step with the encoder. 0 = counter advances per accepted word.

Ports:
- CLK  in  1  clock. All state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- XIN  in  NBITS  encoded word.
- IN_VALID  in  1  XIN is valid this cycle.
- IN_READY  out  1  a word can be accepted this cycle.
- SYNC  in  1  load the counter from SYNC_VAL.
- SYNC_VAL  in  NBITS  counter load value.
- SUM  out  NBITS  decoded A+B at the FIFO head.
- SEQ  out  NBITS  key used to decode the head word.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  consumer takes the head word.
- LEVEL  out  clog2(DEPTH)+1  FIFO occupancy.
- OVERFLOW  out  1  sticky flag: a word was dropped (FREE_RUN=1 only).

Behaviour:
- Reset (RST=1 at an edge): CNT=0, FIFO emptied, OUT_VALID=0, SUM=0, SEQ=0, LEVEL=0, OVERFLOW=0. IN_READY=1 from the first cycle with RST low. Reset mid-stream discards all buffered words.
- Key computation in a cycle where CNT=c:
  - SYNC=1: key = SYNC_VAL.
  - otherwise: key = c+1 mod 2^NBITS.
- Counter update:
  - FREE_RUN=1: CNT <= key every non-reset cycle, whether or not a word is accepted.
  - FREE_RUN=0: CNT <= key only on an accept cycle or when SYNC=1. SYNC without a word still loads the counter.
- Accept: IN_VALID & IN_READY. Push {SUM = XIN + key mod 2^NBITS, SEQ = key}. Arithmetic is unsigned, carry discarded.
- IN_READY = (LEVEL != DEPTH). It depends on the registered state only. A pop in the same cycle does not free a slot for that cycle's push.
- Drop: IN_VALID=1 while full.
  - FREE_RUN=1: word lost, OVERFLOW <= 1. OVERFLOW clears only on RST.
  - FREE_RUN=0: this is legal backpressure; the source holds XIN, OVERFLOW is unaffected.
- Pop: OUT_VALID & OUT_READY. The head advances at the edge. SUM, SEQ, OUT_VALID and LEVEL are registered/derived from FIFO state.
- Latency: a word accepted at edge k is visible on SUM/SEQ with OUT_VALID=1 after edge k. There is no combinational bypass.
- Simultaneous push and pop (not full): LEVEL unchanged, order preserved.
- Pop when empty has no effect. SUM/SEQ hold their last values while OUT_VALID=0.
- Wrap-around:
  - CNT, key and the FIFO read/write pointers all wrap modulo their range.
  - Full and empty are distinguished by an extra pointer bit.

Test Plan:
1. Lock-step decode.
   - Stimulus: FREE_RUN=1. Encoder fed A=3,B=4, then A=10,B=20, from the first post-reset cycle; its XOUT (6, then 28) drives XIN with IN_VALID=1.
   - Required: SUM=7,SEQ=1, then SUM=30,SEQ=2, each one cycle after accept.
2. Counter wrap.
   - Stimulus: SYNC=1,SYNC_VAL=255 with XIN=0x05. Next cycle XIN=0x10.
   - Required: first word SUM=0x04,SEQ=255. Second word SEQ=0, SUM=0x10.
3. Backpressure and overflow.
   - Stimulus: FREE_RUN=1, DEPTH=4, OUT_READY=0, six consecutive valid words.
   - Required: LEVEL=4, IN_READY=0 after the 4th, OVERFLOW=1. Releasing OUT_READY drains exactly the first 4 words in order, with SEQ 1,2,3,4.
4. Tagged mode.
   - Stimulus: FREE_RUN=0, valid words only on cycles 2 and 7 after reset.
   - Required: SEQ=1 and SEQ=2. OVERFLOW stays 0 when full.
5. Full with simultaneous pop.
   - Stimulus: FIFO full, OUT_READY=1 and IN_VALID=1.
   - Required: no accept that cycle, LEVEL=3 next. Accept on the following cycle.
6. Reset mid-operation.
   - Stimulus: 3 words buffered, OVERFLOW=1, RST=1 for one cycle.
   - Required: OUT_VALID=0, LEVEL=0, OVERFLOW=0. The next word decodes with SEQ=1.

Source files
------------

// File: rtl/named_decode.sv
// rtl/named_decode.sv - named-counter decoder with tagged output FIFO
//
// Purpose:
//   Regenerates the encoder's running counter, restores SUM = XIN + key and
//   tags each word with its key. Decoded words are buffered in a DEPTH-entry
//   FIFO drained through a valid/ready handshake.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   XIN        encoded word
//   IN_VALID   XIN valid this cycle
//   IN_READY   a word can be accepted (registered FIFO state only)
//   SYNC       load counter from SYNC_VAL (key = SYNC_VAL this cycle)
//   SYNC_VAL   counter load value
//   SUM        decoded word at the FIFO head
//   SEQ        key used to decode the head word
//   OUT_VALID  FIFO non-empty
//   OUT_READY  consumer takes the head word
//   LEVEL      FIFO occupancy
//   OVERFLOW   sticky: a word was dropped while full (FREE_RUN=1 only)

module named_decode #(
    parameter int NBITS    = 8,
    parameter int DEPTH    = 4,
    parameter bit FREE_RUN = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NBITS-1:0]         XIN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic                     SYNC,
    input  logic [NBITS-1:0]         SYNC_VAL,
    output logic [NBITS-1:0]         SUM,
    output logic [NBITS-1:0]         SEQ,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [NBITS-1:0] cnt;
    logic [NBITS-1:0] key;
    logic [NBITS-1:0] sum_in;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;

    logic [NBITS-1:0] sum_mem [DEPTH];
    logic [NBITS-1:0] seq_mem [DEPTH];

    logic             accept;
    logic             pop;
    logic             cnt_load;

    logic             head_load;
    logic [NBITS-1:0] head_sum;
    logic [NBITS-1:0] head_seq;

    assign LEVEL     = wr_ptr - rd_ptr;
    assign IN_READY  = (LEVEL != FULL_LVL);
    assign OUT_VALID = (wr_ptr != rd_ptr);

    assign key    = SYNC ? SYNC_VAL : cnt + NBITS'(1);
    assign sum_in = XIN + key;

    assign accept = IN_VALID & IN_READY;
    assign pop    = OUT_VALID & OUT_READY;

    assign cnt_load   = FREE_RUN ? 1'b1 : (accept | SYNC);
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

    // SUM/SEQ are registered copies of the head entry so they can hold their
    // last value once the FIFO runs empty. When the FIFO would be empty after
    // this cycle's pop, the only possible new head is the word pushed now.
    always_comb begin
        head_load = 1'b0;
        head_sum  = sum_in;
        head_seq  = key;
        if (rd_ptr_nxt == wr_ptr) begin
            head_load = accept;
        end else begin
            head_load = 1'b1;
            head_sum  = sum_mem[rd_ptr_nxt[AW-1:0]];
            head_seq  = seq_mem[rd_ptr_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            sum_mem[wr_ptr[AW-1:0]] <= sum_in;
            seq_mem[wr_ptr[AW-1:0]] <= key;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            SUM      <= '0;
            SEQ      <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (cnt_load) begin
                cnt <= key;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            rd_ptr <= rd_ptr_nxt;
            if (head_load) begin
                SUM <= head_sum;
                SEQ <= head_seq;
            end
            // In tagged mode a full FIFO is ordinary backpressure.
            if (FREE_RUN && IN_VALID && !IN_READY) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_named_decode.sv
// tb/tb_named_decode.sv - scoreboard bench for named_decode, both counter modes

module tb_named_decode;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] xin;
    logic       in_valid;
    logic       sync;
    logic [7:0] sync_val;
    logic       out_ready;

    logic       in_ready_o  [2];
    logic [7:0] sum_o       [2];
    logic [7:0] seq_o       [2];
    logic       out_valid_o [2];
    logic [2:0] level_o     [2];
    logic       overflow_o  [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    // Reference model state, index 0 = free-running DUT, 1 = tagged DUT.
    int          m_cnt      [2];
    int          m_lvl      [2];
    bit          m_ovf      [2];
    int          m_last_sum [2];
    int          m_last_seq [2];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    named_decode #(.NBITS(8), .DEPTH(DEPTH), .FREE_RUN(1'b1)) dut_fr (
        .CLK(clk), .RST(rst), .XIN(xin), .IN_VALID(in_valid), .IN_READY(in_ready_o[0]),
        .SYNC(sync), .SYNC_VAL(sync_val), .SUM(sum_o[0]), .SEQ(seq_o[0]),
        .OUT_VALID(out_valid_o[0]), .OUT_READY(out_ready), .LEVEL(level_o[0]),
        .OVERFLOW(overflow_o[0])
    );

    named_decode #(.NBITS(8), .DEPTH(DEPTH), .FREE_RUN(1'b0)) dut_tg (
        .CLK(clk), .RST(rst), .XIN(xin), .IN_VALID(in_valid), .IN_READY(in_ready_o[1]),
        .SYNC(sync), .SYNC_VAL(sync_val), .SUM(sum_o[1]), .SEQ(seq_o[1]),
        .OUT_VALID(out_valid_o[1]), .OUT_READY(out_ready), .LEVEL(level_o[1]),
        .OVERFLOW(overflow_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, int m, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, m, act, exp, $time);
        end
    endtask

    // One clock of the reference behaviour. The monitor has already removed
    // the popped word from the expected queue at the preceding negedge.
    task automatic model_edge(int m);
        int key;
        bit acc;
        bit fr;
        fr = (m == 0);
        if (rst) begin
            m_cnt[m] = 0; m_lvl[m] = 0; m_ovf[m] = 0;
            m_last_sum[m] = 0; m_last_seq[m] = 0;
            if (m == 0) q0.delete(); else q1.delete();
            return;
        end
        key = sync ? int'(sync_val) : (m_cnt[m] + 1) % 256;
        acc = in_valid && (m_lvl[m] != DEPTH);
        if (in_valid && !acc && fr) m_ovf[m] = 1;
        if (fr || acc || sync) m_cnt[m] = key;
        if (out_ready && m_lvl[m] > 0) m_lvl[m]--;
        if (acc) begin
            if (m == 0) q0.push_back({8'((int'(xin) + key) % 256), 8'(key)});
            else        q1.push_back({8'((int'(xin) + key) % 256), 8'(key)});
            m_lvl[m]++;
        end
    endtask

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
    end

    task automatic mon(int m);
        logic [15:0] f;
        int sz;
        chk("in_ready", m, int'(in_ready_o[m]), int'(m_lvl[m] != DEPTH));
        chk("level", m, int'(level_o[m]), m_lvl[m]);
        chk("overflow", m, int'(overflow_o[m]), int'(m_ovf[m]));
        chk("out_valid", m, int'(out_valid_o[m]), int'(m_lvl[m] > 0));
        sz = (m == 0) ? q0.size() : q1.size();
        if (m_lvl[m] > 0) begin
            if (sz == 0) begin
                chk("expected_queue_nonempty", m, 0, 1);
            end else begin
                f = (m == 0) ? q0[0] : q1[0];
                chk("sum", m, int'(sum_o[m]), int'(f[15:8]));
                chk("seq", m, int'(seq_o[m]), int'(f[7:0]));
                m_last_sum[m] = int'(f[15:8]);
                m_last_seq[m] = int'(f[7:0]);
                if (out_ready) begin
                    if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end else begin
            chk("sum_hold", m, int'(sum_o[m]), m_last_sum[m]);
            chk("seq_hold", m, int'(seq_o[m]), m_last_seq[m]);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0);
            mon(1);
        end
    end

    task automatic cyc(bit r, bit v, logic [7:0] x, bit s, logic [7:0] sv, bit ordy);
        rst = r; in_valid = v; xin = x; sync = s; sync_val = sv; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ordy_pct;
        rst = 1'b1; in_valid = 1'b0; xin = '0; sync = 1'b0; sync_val = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        started = 1;

        // Lock-step decode: encoder words 6 and 28 from the first post-reset cycle.
        cyc(0, 1, 8'd6, 0, 0, 1);
        chk("t1_sum0", 0, int'(sum_o[0]), 7);
        chk("t1_seq0", 0, int'(seq_o[0]), 1);
        cyc(0, 1, 8'd28, 0, 0, 1);
        chk("t1_sum1", 0, int'(sum_o[0]), 30);
        chk("t1_seq1", 0, int'(seq_o[0]), 2);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);

        // Counter wrap through SYNC.
        cyc(0, 1, 8'h05, 1, 8'd255, 1);
        for (int m = 0; m < 2; m++) begin
            chk("t2_sum0", m, int'(sum_o[m]), 4);
            chk("t2_seq0", m, int'(seq_o[m]), 255);
        end
        cyc(0, 1, 8'h10, 0, 0, 1);
        for (int m = 0; m < 2; m++) begin
            chk("t2_sum1", m, int'(sum_o[m]), 16);
            chk("t2_seq1", m, int'(seq_o[m]), 0);
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 1);

        // Backpressure and overflow.
        cyc(1, 0, 0, 0, 0, 0);
        repeat (6) cyc(0, 1, 8'($urandom), 0, 0, 0);
        chk("t3_level", 0, int'(level_o[0]), 4);
        chk("t3_in_ready", 0, int'(in_ready_o[0]), 0);
        chk("t3_overflow", 0, int'(overflow_o[0]), 1);
        chk("t3_overflow_tagged", 1, int'(overflow_o[1]), 0);
        chk("t3_head_seq", 0, int'(seq_o[0]), 1);
        repeat (6) cyc(0, 0, 0, 0, 0, 1);

        // Tagged mode: words on cycles 2 and 7 after reset.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'($urandom), 0, 0, 0);
        chk("t4_seq_first", 1, int'(seq_o[1]), 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'($urandom), 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t4_seq_second", 1, int'(seq_o[1]), 2);
        repeat (6) cyc(0, 1, 8'($urandom), 0, 0, 0);
        chk("t4_level_full", 1, int'(level_o[1]), 4);
        chk("t4_no_overflow", 1, int'(overflow_o[1]), 0);

        // Full FIFO with a simultaneous pop: no accept, then accept next cycle.
        cyc(0, 1, 8'($urandom), 0, 0, 1);
        for (int m = 0; m < 2; m++) chk("t5_level_after_pop", m, int'(level_o[m]), 3);
        cyc(0, 1, 8'($urandom), 0, 0, 0);
        for (int m = 0; m < 2; m++) chk("t5_level_after_push", m, int'(level_o[m]), 4);

        // Reset mid-operation with three words buffered.
        cyc(0, 0, 0, 0, 0, 1);
        chk("t6_level_before", 0, int'(level_o[0]), 3);
        chk("t6_overflow_before", 0, int'(overflow_o[0]), 1);
        cyc(1, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            chk("t6_out_valid", m, int'(out_valid_o[m]), 0);
            chk("t6_level", m, int'(level_o[m]), 0);
            chk("t6_overflow", m, int'(overflow_o[m]), 0);
        end
        cyc(0, 1, 8'($urandom), 0, 0, 0);
        for (int m = 0; m < 2; m++) chk("t6_seq_after_reset", m, int'(seq_o[m]), 1);

        // Randomized traffic with varying drain rate, sporadic SYNC and reset.
        for (int blk = 0; blk < 6; blk++) begin
            ordy_pct = 20 + blk * 15;
            for (int i = 0; i < 500; i++) begin
                cyc($urandom_range(0, 299) == 0,
                    $urandom_range(0, 3) != 0,
                    8'($urandom),
                    $urandom_range(0, 19) == 0,
                    8'($urandom),
                    $urandom_range(0, 99) < ordy_pct);
            end
        end
        repeat (8) cyc(0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
